// File: rtl/demux_pkg.sv
// Shared constants and select encoding for the buffered 1:4 result demultiplexer.
package demux_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned DROP_W_DEFAULT = 8;
  localparam int unsigned NUM_CH         = 4;
  localparam int unsigned SEL_W          = 2;

  typedef enum logic [SEL_W-1:0] {
    CH0 = 2'b00,
    CH1 = 2'b01,
    CH2 = 2'b10,
    CH3 = 2'b11
  } ch_sel_e;

  // One-hot destination for a channel select.
  function automatic logic [NUM_CH-1:0] sel_onehot(input ch_sel_e sel);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    case (sel)
      CH0:     oh[0] = 1'b1;
      CH1:     oh[1] = 1'b1;
      CH2:     oh[2] = 1'b1;
      CH3:     oh[3] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel; a load overrides a drain
// in the same cycle so a streaming channel never bubbles.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              can_accept
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign can_accept = ~valid_q | out_ready;

endmodule

// File: rtl/demux1_4_buf.sv
// Buffered 1:4 demultiplexer: routes one valid/ready result stream to four
// independently drained one-entry channel slots; disabled channels drop and count.
module demux1_4_buf
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DROP_W = DROP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [DROP_W-1:0] drop_cnt
);

  ch_sel_e           sel;
  logic [NUM_CH-1:0] sel_oh;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] can_accept;
  logic              sel_en;
  logic              in_fire;
  logic              drop_fire;
  logic [DATA_W-1:0] slot_data [NUM_CH];
  logic [DROP_W-1:0] drop_q, drop_d;

  assign sel = ch_sel_e'(in_sel);

  // Disabled destinations always accept (and drop); otherwise a single mux
  // passes the selected slot's can_accept straight through.
  always_comb begin
    sel_oh    = sel_onehot(sel);
    sel_en    = ch_en[in_sel];
    in_ready  = sel_en ? can_accept[in_sel] : 1'b1;
    in_fire   = in_valid & in_ready;
    load      = {NUM_CH{in_fire & sel_en}} & sel_oh;
    drop_fire = in_fire & ~sel_en;
  end

  always_comb begin
    drop_d = drop_q;
    if (drop_fire && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[g]),
      .load_data (in_data),
      .out_ready (out_ready[g]),
      .out_valid (out_valid[g]),
      .out_data  (slot_data[g]),
      .can_accept(can_accept[g])
    );
  end

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux1_4_buf.sv
// Self-checking bench for demux1_4_buf: vector table, directed corner sequences
// and constrained-random traffic against a per-channel behavioural model.
module tb_demux1_4_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ch_en;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  drop_cnt;

  demux1_4_buf #(.DATA_W(32), .DROP_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ch_en    (ch_en),
    .out_data0(out_data0),
    .out_data1(out_data1),
    .out_data2(out_data2),
    .out_data3(out_data3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what each channel holds and how many words were dropped.
  logic        m_v [4];
  logic [31:0] m_d [4];
  int          m_drop;
  logic        last_stall;

  typedef struct {
    logic [3:0]  en;
    logic [1:0]  sel;
    logic        v;
    logic [31:0] d;
    logic [3:0]  ordy;
    logic        rdy;
    logic [3:0]  ov;
    logic [7:0]  drop;
    logic [31:0] word;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dout(input int i);
    case (i)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  function automatic logic m_rdy();
    return !ch_en[in_sel] || !m_v[in_sel] || out_ready[in_sel];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
    end
    m_drop = 0;
    last_stall = 1'b0;
  endtask

  task automatic check_model();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model_valid%0d", i), 64'(out_valid[i]), 64'(m_v[i]));
      chk($sformatf("model_data%0d", i), 64'(dout(i)), 64'(m_d[i]));
    end
    chk("model_drop", 64'(drop_cnt), 64'(m_drop));
  endtask

  // One clock: check in_ready, predict next state, advance, compare.
  task automatic tick();
    logic        fire;
    logic        nv [4];
    logic [31:0] nd [4];
    int          ndrop;
    #1;
    chk("model_in_ready", 64'(in_ready), 64'(m_rdy()));
    fire = in_valid && m_rdy();
    last_stall = in_valid && !m_rdy();
    nv = m_v;
    nd = m_d;
    ndrop = m_drop;
    for (int i = 0; i < 4; i++) begin
      if (m_v[i] && out_ready[i]) nv[i] = 1'b0;
    end
    if (fire) begin
      if (ch_en[in_sel]) begin
        nv[in_sel] = 1'b1;
        nd[in_sel] = in_data;
      end else if (ndrop < 255) begin
        ndrop++;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      m_v = nv;
      m_d = nd;
      m_drop = ndrop;
    end
    check_model();
  endtask

  task automatic drain_all();
    in_valid  = 1'b0;
    out_ready = 4'hF;
    tick();
    tick();
    out_ready = 4'h0;
  endtask

  task automatic send(input logic [1:0] s, input logic [31:0] d);
    in_sel   = s;
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{4'hF, 2'd1, 1'b1, 32'hDEADBEEF, 4'b0000, 1'b1, 4'b0010, 8'd0, 32'hDEADBEEF};
    tbl[1] = '{4'hF, 2'd1, 1'b1, 32'h11111111, 4'b0000, 1'b0, 4'b0010, 8'd0, 32'hDEADBEEF};
    tbl[2] = '{4'hF, 2'd1, 1'b1, 32'h11111111, 4'b0010, 1'b1, 4'b0010, 8'd0, 32'h11111111};
    tbl[3] = '{4'hF, 2'd3, 1'b1, 32'h33333333, 4'b0000, 1'b1, 4'b1010, 8'd0, 32'h33333333};
    tbl[4] = '{4'h7, 2'd3, 1'b1, 32'h44444444, 4'b0000, 1'b1, 4'b1010, 8'd1, 32'h33333333};
    tbl[5] = '{4'h7, 2'd0, 1'b1, 32'h00000005, 4'b1010, 1'b1, 4'b0001, 8'd1, 32'h00000005};
    tbl[6] = '{4'hF, 2'd2, 1'b0, 32'hAAAAAAAA, 4'b0000, 1'b1, 4'b0001, 8'd1, 32'h00000000};
    tbl[7] = '{4'hF, 2'd0, 1'b1, 32'h66666666, 4'b0000, 1'b0, 4'b0001, 8'd1, 32'h00000005};
    tbl[8] = '{4'hE, 2'd0, 1'b1, 32'h77777777, 4'b0000, 1'b1, 4'b0001, 8'd2, 32'h00000005};
    tbl[9] = '{4'hE, 2'd2, 1'b1, 32'h88888888, 4'b0001, 1'b1, 4'b0100, 8'd2, 32'h88888888};

    rst = 1'b1;
    in_data = '0;
    in_sel = '0;
    in_valid = 1'b0;
    ch_en = 4'hF;
    out_ready = 4'h0;
    model_reset();
    #1;
    chk("reset_valid", 64'(out_valid), 64'h0);
    chk("reset_drop", 64'(drop_cnt), 64'h0);
    chk("reset_in_ready", 64'(in_ready), 64'h1);
    tick();
    tick();
    rst = 1'b0;

    // Vector table from an empty block.
    for (int k = 0; k < 10; k++) begin
      ch_en     = tbl[k].en;
      in_sel    = tbl[k].sel;
      in_valid  = tbl[k].v;
      in_data   = tbl[k].d;
      out_ready = tbl[k].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", k), 64'(in_ready), 64'(tbl[k].rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", k), 64'(out_valid), 64'(tbl[k].ov));
      chk($sformatf("vec%0d_drop", k), 64'(drop_cnt), 64'(tbl[k].drop));
      chk($sformatf("vec%0d_word", k), 64'(dout(int'(tbl[k].sel))), 64'(tbl[k].word));
    end
    in_valid = 1'b0;
    ch_en = 4'hF;
    drain_all();

    // Backpressure on a full channel 3, then release.
    send(2'd3, 32'hA5A5_0003);
    in_sel = 2'd3;
    in_data = 32'hB6B6_0003;
    in_valid = 1'b1;
    #1;
    chk("bp_in_ready_low", 64'(in_ready), 64'h0);
    tick();
    chk("bp_hold_data", 64'(out_data3), 64'hA5A5_0003);
    chk("bp_hold_valid", 64'(out_valid[3]), 64'h1);
    out_ready = 4'b1000;
    #1;
    chk("bp_in_ready_pass", 64'(in_ready), 64'h1);
    tick();
    chk("bp_new_data", 64'(out_data3), 64'hB6B6_0003);
    chk("bp_new_valid", 64'(out_valid[3]), 64'h1);
    in_valid = 1'b0;
    drain_all();

    // Streaming to channel 0 with the consumer always ready.
    out_ready = 4'b0001;
    in_sel = 2'd0;
    in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_data = 32'(k);
      tick();
      chk($sformatf("stream%0d_valid", k), 64'(out_valid[0]), 64'h1);
      chk($sformatf("stream%0d_data", k), 64'(out_data0), 64'(k));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 64'(out_valid[0]), 64'h0);
    drain_all();

    // Drop path and counter saturation.
    ch_en = 4'b1011;
    in_sel = 2'd2;
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      in_data = $urandom;
      #1;
      chk("sat_in_ready", 64'(in_ready), 64'h1);
      tick();
    end
    in_valid = 1'b0;
    chk("sat_drop", 64'(drop_cnt), 64'd255);
    chk("sat_valid2", 64'(out_valid[2]), 64'h0);

    // Disable while full: the buffered word still drains, no drop.
    ch_en = 4'hF;
    send(2'd0, 32'hC0C0_1234);
    ch_en = 4'b1110;
    out_ready = 4'b0001;
    #1;
    chk("dis_data", 64'(out_data0), 64'hC0C0_1234);
    chk("dis_valid_before", 64'(out_valid[0]), 64'h1);
    tick();
    chk("dis_valid_after", 64'(out_valid[0]), 64'h0);
    chk("dis_drop", 64'(drop_cnt), 64'd255);
    out_ready = 4'h0;
    ch_en = 4'hF;

    // Reset mid-stream with slot 2 full.
    send(2'd2, 32'h2222_BEEF);
    chk("rst_pre_valid", 64'(out_valid), 64'b0100);
    in_sel = 2'd2;
    in_data = 32'h9999_9999;
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_valid", 64'(out_valid), 64'h0);
    chk("rst_mid_drop", 64'(drop_cnt), 64'h0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'h1);
    chk("rst_mid_data2", 64'(out_data2), 64'h0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    out_ready = 4'hF;
    tick();
    chk("rst_after_valid", 64'(out_valid), 64'h0);
    out_ready = 4'h0;

    // Constrained-random traffic; stalled words are held at the source.
    for (int k = 0; k < 1500; k++) begin
      if (!last_stall) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = $urandom;
      end
      for (int i = 0; i < 4; i++) begin
        ch_en[i]     = 1'($urandom_range(0, 5) != 0);
        out_ready[i] = 1'($urandom_range(0, 1));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux1_4_buf.md
# demux1_4_buf

- Buffered 1-to-4 demultiplexer: a single 32-bit valid/ready producer stream is routed by a 2-bit select to one of four consumer channels.
- Each channel has its own one-entry output register, so a stalled consumer never blocks another channel's already-buffered data.
- It sits on the write-back/result side of the pipeline and distributes one result source to up to four consumers.
- It is the distribution counterpart of the 4:1 operand select muxes.

## Interface
Parameters:
- DATA_W, 32, width of data path and every channel.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  payload from producer.
- in_sel  in  2  destination channel: 00→ch0, 01→ch1, 10→ch2, 11→ch3.
- in_valid  in  1  producer offers in_data/in_sel.
- in_ready  out  1  block accepts this cycle.
- ch_en  in  4  per-channel enable; a disabled channel drops its traffic.
- out_data0..out_data3  out  DATA_W  per-channel registered payload.
- out_valid  out  4  bit i: channel i slot holds data.
- out_ready  in  4  bit i: consumer i takes data this cycle.
- drop_cnt  out  DROP_W  count of words dropped to disabled channels; saturates.

## Operation
- Transfer definitions:
  - in_fire = in_valid & in_ready.
  - out_fire[i] = out_valid[i] & out_ready[i].
- in_ready (combinational):
  - 1 if ch_en[in_sel] = 0.
  - Otherwise ~out_valid[in_sel] | out_ready[in_sel].
  - This gives a pass-through path from out_ready to in_ready. The path is intentional and must stay a single gate level deep.
- Channel slot i loads when in_fire & in_sel = i & ch_en[i]:
  - out_data_i ← in_data.
  - out_valid[i] ← 1.
- Channel slot i clears when out_fire[i] and it is not loaded in the same cycle. Otherwise it holds.
- Simultaneous drain and load on the same channel:
  - The new word replaces the drained one.
  - out_valid[i] stays 1, with no bubble.
- Drop path, when in_fire & ch_en[in_sel] = 0:
  - The word is discarded.
  - No slot changes.
  - drop_cnt increments, holding at 2^DROP_W−1.
- Non-selected channels are unaffected by input activity and drain independently.
- ch_en affects acceptance only. A full slot whose enable is cleared keeps its data and still drains normally.
- out_data_i is unchanged while out_valid[i] = 0 (last value held). Consumers must ignore it.
- Producer obligation: in_data and in_sel stay stable while in_valid & ~in_ready.
- No reordering exists within a channel. Order across channels is not defined.

## Timing
- Reset values (asynchronous, immediate on rst high):
  - out_valid = 0000.
  - out_data0..3 = 0.
  - drop_cnt = 0.
  - in_ready then follows the combinational rule with all slots empty, so it is 1.
- Reset mid-operation discards all buffered words. No partial transfer survives.
- Latency: a word accepted at edge k appears with out_valid[i] = 1 after edge k, i.e. in cycle k+1.
- Throughput: 1 word/cycle to a single channel while its out_ready is held 1. Back-to-back writes to different channels also run at 1 word/cycle.
- Stall: with slot i full and out_ready[i] = 0, in_sel = i causes in_ready = 0 and the word waits at the source.
- drop_cnt updates on the edge of the dropping transfer and is visible the next cycle.

## Structure
- Shared package demux_pkg holds:
  - DATA_W default (32).
  - NUM_CH = 4.
  - Select encodings CH0 = 2'b00, CH1 = 2'b01, CH2 = 2'b10, CH3 = 2'b11.
- Sub-module demux_slot is the one-entry register for one channel:
  - Inputs: clk, rst, load, load_data, out_ready.
  - Outputs: out_valid, out_data, can_accept = ~out_valid | out_ready.
  - It is instantiated four times.
- The top level holds:
  - select decode.
  - in_ready mux (picks can_accept of the selected channel, or forces 1 when disabled).
  - drop counter.

## Test plan
- Reset then idle: assert rst mid-stream with slot 2 full → out_valid = 0000, drop_cnt = 0, in_ready = 1 immediately. Slot 2's data is not presented after release.
- Single route: ch_en = 1111, in_sel = 01, in_data = 0xDEADBEEF, out_ready = 0000 → after one edge out_valid = 0010, out_data1 = 0xDEADBEEF. Other out_valid bits stay 0.
- Backpressure: slot 3 full, out_ready[3] = 0, in_sel = 11, in_valid = 1 → in_ready = 0 and slot contents unchanged. Raising out_ready[3] then gives in_ready = 1 the same cycle and out_data3 = the new word next cycle, with out_valid[3] held 1.
- Streaming: 4 words 0x1..0x4 to ch0 with out_ready[0] = 1 on consecutive cycles → consumer sees 0x1..0x4 in order on 4 consecutive cycles, no bubble.
- Drop and saturation: ch_en = 1011, send 300 words with in_sel = 10 → in_ready always 1, out_valid[2] stays 0, drop_cnt ends at 255.
- Disable while full: fill ch0, clear ch_en[0], then raise out_ready[0] → the word is delivered, out_valid[0] falls, drop_cnt unchanged.
